stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Timekeeping core of the stopwatch: consumes the single-cycle rising-edge pulses produced by the button debouncers plus two clock-enable ticks, and maintains an MM:SS BCD time value with run/pause control and a manual adjust mode. Sits directly downstream of the debouncers and upstream of the seven-segment display driver, all on the system clock `clk`.

## Interface
- `MAX_MIN`, 59, highest minutes value before wrap to 00; must be 1..99.
- `clk`  input  1  system clock; the debouncer pulses and ticks are synchronous to it.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pause_pulse`  input  1  one-cycle pulse from the pause debouncer; toggles run/pause.
- `clr_pulse`  input  1  one-cycle pulse from the reset-button debouncer; clears the time.
- `adj`  input  1  level, switch; 1 = adjust mode.
- `sel`  input  1  level, switch; field to adjust: 1 = seconds, 0 = minutes.
- `tick_1hz`  input  1  one-cycle enable, 1 Hz.
- `tick_2hz`  input  1  one-cycle enable, 2 Hz.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  output  4 each  BCD digits, registered.
- `running`  output  1  1 in RUN state.
- `field_blank`  output  2  bit1 = blank minutes, bit0 = blank seconds (display hint).

## Operation
- FSM states: RUN, PAUSED. `pause_pulse` toggles RUN↔PAUSED in any mode, including adjust. `running` = (state == RUN).
- Precedence, evaluated per cycle: `clr_pulse` > adjust > normal count.
- `clr_pulse`: all digits to 0 next cycle; FSM state unchanged; the blink phase resets to 0.
- Normal count (`adj`=0, state RUN, `tick_1hz`=1): seconds +1. At seconds 59: seconds → 00 and minutes +1. At minutes `MAX_MIN` with seconds 59: wrap to 00:00. `tick_2hz` is ignored.
- PAUSED with `adj`=0: time holds.
- Adjust (`adj`=1): `tick_1hz` is ignored. On `tick_2hz`, the field selected by `sel` increments by 1, wrapping 59 → 00 for seconds and `MAX_MIN` → 00 for minutes. There is no carry between fields. The unselected field holds. Adjust proceeds regardless of RUN/PAUSED.
- Digits are always valid BCD: ones digits 0–9, tens of seconds 0–5, tens of minutes per `MAX_MIN`.
- `sel` or `adj` changes take effect on the next tick. Counting resumes from the adjusted value when `adj` falls.

## Timing
- Reset (`rst_n`=0, asynchronous): digits 0, state RUN, `running`=1, `field_blank`=2'b00, blink phase 0.
- Release of `rst_n` is synchronous at the next `clk` edge.
- All outputs are registered. An input sampled at edge N is visible after edge N, so latency is 1 cycle.
- Simultaneous `pause_pulse` and `tick_1hz`: the tick uses the pre-toggle state. For example, if the state is RUN, the count increments and the state becomes PAUSED.
- Simultaneous `clr_pulse` and any tick: the result is 00:00 and the tick is lost.
- Simultaneous `clr_pulse` and `pause_pulse`: clear is applied and the state also toggles.
- A pulse held high for k cycles is treated as k pulses. Upstream guarantees single-cycle pulses.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - A blink phase register toggles on each `tick_2hz` while `adj`=1, and is forced to 0 while `adj`=0.
  - While `adj`=1, `field_blank` = phase ? (`sel` ? 2'b01 : 2'b10) : 2'b00. Otherwise it is 2'b00.
- `STOPWATCH_BLINK_EN` undefined: `field_blank` is tied to 2'b00 and there is no phase register. The port remains present.

## Test plan
- Reset then 61 `tick_1hz` → 01:01, `running`=1; assert `rst_n` low mid-count → immediately 00:00.
- Preload 59:58 via adjust, then 2 `tick_1hz` in RUN → 00:00 wrap; 58 → 59 → 00 visible on `sec_ones`/`sec_tens`.
- RUN with `pause_pulse` and `tick_1hz` in the same cycle at 00:05 → 00:06, `running`=0; 3 more `tick_1hz` → still 00:06.
- `adj`=1, `sel`=1 at 00:58, 3 `tick_2hz` → 00:01, minutes stay 00; `tick_1hz` during adjust has no effect; `sel`=0, 2 `tick_2hz` → 02:01.
- At 12:34, `clr_pulse` coincident with `tick_1hz` while RUN → 00:00, `running`=1; the same test while PAUSED → 00:00, `running`=0.
- With `STOPWATCH_BLINK_EN`: `adj`=1, `sel`=0, 4 `tick_2hz` → `field_blank` sequence 10, 00, 10, 00; `adj`→0 → 00. Without the macro, `field_blank` is 00 throughout.

Source files
------------

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch core with run/pause FSM, clear and manual field adjust.
// Define STOPWATCH_BLINK_EN to add the adjust-mode field blink hint.
module stopwatch_core #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_pulse,
    input  logic       clr_pulse,
    input  logic       adj,
    input  logic       sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [1:0] field_blank
);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

    state_t     state_q;
    logic       running_q;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic [3:0] mt_inc, mo_inc, st_inc, so_inc;
    logic       sec_wrap, min_wrap;

    assign sec_wrap = (st_q == 4'd5) && (so_q == 4'd9);
    assign min_wrap = (mt_q == MAX_MT) && (mo_q == MAX_MO);

    // Single-field increments with wrap; carry into minutes is chosen below.
    always_comb begin
        so_inc = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
        st_inc = st_q;
        if (so_q == 4'd9)
            st_inc = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
        mo_inc = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
        mt_inc = (mo_q == 4'd9) ? mt_q + 4'd1 : mt_q;
        if (min_wrap) begin
            mo_inc = 4'd0;
            mt_inc = 4'd0;
        end
    end

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clr_pulse) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = 4'd0;
            so_d = 4'd0;
        end else if (adj) begin
            if (tick_2hz) begin
                if (sel) begin
                    st_d = st_inc;
                    so_d = so_inc;
                end else begin
                    mt_d = mt_inc;
                    mo_d = mo_inc;
                end
            end
        end else if (state_q == RUN && tick_1hz) begin
            st_d = st_inc;
            so_d = so_inc;
            if (sec_wrap) begin
                mt_d = mt_inc;
                mo_d = mo_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            mt_q      <= 4'd0;
            mo_q      <= 4'd0;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
            if (pause_pulse) begin
                state_q   <= (state_q == RUN) ? PAUSED : RUN;
                running_q <= (state_q != RUN);
            end
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign running  = running_q;

`ifdef STOPWATCH_BLINK_EN
    logic       phase_q, phase_d;
    logic [1:0] blank_q, blank_d;

    always_comb begin
        phase_d = phase_q;
        if (clr_pulse || !adj)
            phase_d = 1'b0;
        else if (tick_2hz)
            phase_d = ~phase_q;
        blank_d = 2'b00;
        if (adj && phase_d)
            blank_d = sel ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            blank_q <= 2'b00;
        end else begin
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    assign field_blank = blank_q;
`else
    assign field_blank = 2'b00;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus a
// randomized run against an integer minutes/seconds reference model.
module tb_stopwatch_core;

    localparam int MAXM = 59;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       clr_pulse = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [1:0] field_blank;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: plain integers
    int m_sec, m_min;
    bit m_run, m_ph;

    stopwatch_core #(.MAX_MIN(MAXM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pause_pulse(pause_pulse),
        .clr_pulse(clr_pulse),
        .adj(adj),
        .sel(sel),
        .tick_1hz(tick_1hz),
        .tick_2hz(tick_2hz),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running(running),
        .field_blank(field_blank)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] shown();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [1:0] exp_blank();
`ifdef STOPWATCH_BLINK_EN
        if (adj && m_ph) return sel ? 2'b01 : 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_sec = 0;
        m_min = 0;
        m_run = 1'b1;
        m_ph  = 1'b0;
    endtask

    task automatic model_edge();
        if (clr_pulse) begin
            m_sec = 0;
            m_min = 0;
        end else if (adj) begin
            if (tick_2hz) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % (MAXM + 1);
            end
        end else if (m_run && tick_1hz) begin
            m_sec = m_sec + 1;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min = (m_min + 1) % (MAXM + 1);
            end
        end
        if (clr_pulse || !adj) m_ph = 1'b0;
        else if (tick_2hz)     m_ph = !m_ph;
        if (pause_pulse) m_run = !m_run;
    endtask

    task automatic step(input bit p, input bit c, input bit t1, input bit t2);
        pause_pulse = p;
        clr_pulse   = c;
        tick_1hz    = t1;
        tick_2hz    = t2;
        @(posedge clk);
        model_edge();
        #1;
        pause_pulse = 1'b0;
        clr_pulse   = 1'b0;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_cmp++;
        if (shown() !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_time got %h want 0000", shown());
        end
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_running got %b want 1", running);
        end
        n_cmp++;
        if (field_blank !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_blank got %b want 00", field_blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count();
        for (int i = 0; i < 61; i++) step(0, 0, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0101 || shown() !== bcd(m_min, m_sec)) begin
            n_bad++;
            $display("FAIL count_61 got %h want 0101", shown());
        end
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL count_running got %b want 1", running);
        end
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if (shown() !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_reset got %h want 0000", shown());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        adj = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
        sel = 1'b1;
        for (int i = 0; i < 58; i++) step(0, 0, 0, 1);
        n_cmp++;
        if (shown() !== 16'h5958) begin
            n_bad++;
            $display("FAIL preload got %h want 5958", shown());
        end
        adj = 1'b0;
        step(0, 0, 1, 0);
        n_cmp++;
        if (shown() !== 16'h5959) begin
            n_bad++;
            $display("FAIL wrap_a got %h want 5959", shown());
        end
        step(0, 0, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0000 || bcd(m_min, m_sec) !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_b got %h want 0000", shown());
        end
    endtask

    task automatic test_pause_tick();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0006 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_tick got %h/%b want 0006/0", shown(), running);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0006) begin
            n_bad++;
            $display("FAIL paused_hold got %h want 0006", shown());
        end
    endtask

    task automatic test_adjust();
        adj = 1'b1;
        sel = 1'b1;
        step(0, 1, 0, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        n_cmp++;
        if (shown() !== 16'h0001) begin
            n_bad++;
            $display("FAIL adj_sec got %h want 0001", shown());
        end
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0001) begin
            n_bad++;
            $display("FAIL adj_1hz got %h want 0001", shown());
        end
        sel = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        n_cmp++;
        if (shown() !== 16'h0201 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL adj_min got %h/%b want 0201/1", shown(), running);
        end
        adj = 1'b0;
        step(0, 0, 0, 0);
    endtask

    task automatic goto_1234();
        adj = 1'b1;
        sel = 1'b0;
        step(0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        sel = 1'b1;
        for (int i = 0; i < 34; i++) step(0, 0, 0, 1);
        adj = 1'b0;
        step(0, 0, 0, 0);
    endtask

    task automatic test_clear();
        goto_1234();
        if (!m_run) step(1, 0, 0, 0);
        n_cmp++;
        if (shown() !== 16'h1234 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_clr got %h/%b want 1234/1", shown(), running);
        end
        step(0, 1, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0000 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_run got %h/%b want 0000/1", shown(), running);
        end
        goto_1234();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        n_cmp++;
        if (shown() !== 16'h0000 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_pause got %h/%b want 0000/0", shown(), running);
        end
        step(1, 1, 0, 0);
        n_cmp++;
        if (shown() !== 16'h0000 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_toggle got %h/%b want 0000/1", shown(), running);
        end
    endtask

    task automatic test_blink();
        logic [1:0] seq [4];
`ifdef STOPWATCH_BLINK_EN
        seq = '{2'b10, 2'b00, 2'b10, 2'b00};
`else
        seq = '{2'b00, 2'b00, 2'b00, 2'b00};
`endif
        adj = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            n_cmp++;
            if (field_blank !== seq[i]) begin
                n_bad++;
                $display("FAIL blink_%0d got %b want %b", i, field_blank, seq[i]);
            end
        end
        step(0, 0, 0, 1);
        adj = 1'b0;
        step(0, 0, 0, 0);
        n_cmp++;
        if (field_blank !== 2'b00) begin
            n_bad++;
            $display("FAIL blink_off got %b want 00", field_blank);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0) sel = ~sel;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_cmp++;
            if (shown() !== bcd(m_min, m_sec) || running !== m_run ||
                field_blank !== exp_blank()) begin
                n_bad++;
                $display("FAIL rand_%0d got %h/%b/%b want %h/%b/%b", i,
                         shown(), running, field_blank,
                         bcd(m_min, m_sec), m_run, exp_blank());
            end
        end
        adj = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause_tick();
        test_adjust();
        test_clear();
        test_blink();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
